// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control sequencer: button debounce, IDLE/RUN/PAUSE/CLEAR FSM, display mux
// Lap capture is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_MS  = 20,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic       Clock_1MSec,
    input  logic       Reset,
    input  logic       Btn_Mode,
    input  logic       Btn_StartStop,
    input  logic       Btn_Clear,
    input  logic       Btn_Lap,
    input  logic [3:0] Hours_S,
    input  logic [5:0] Mins_S,
    input  logic [5:0] Secs_S,
    input  logic [9:0] MSecs_S,
    output logic       Control,
    output logic       Start_S,
    output logic       Stop_S,
    output logic       Reset_S,
    output logic [3:0] Disp_Hours,
    output logic [5:0] Disp_Mins,
    output logic [5:0] Disp_Secs,
    output logic [9:0] Disp_MSecs,
    output logic       Lap_Active,
    output logic [1:0] State
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_CLEAR = 2'b11;

    localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_MS - 1);
    localparam logic [3:0] CLR_LAST = 4'(CLEAR_CYCLES - 1);

`ifdef STOPWATCH_LAP_EN
    localparam int NB = 4;
    logic [NB-1:0] raw;
    assign raw = {Btn_Lap, Btn_Clear, Btn_StartStop, Btn_Mode};
`else
    localparam int NB = 3;
    logic [NB-1:0] raw;
    logic          unused_lap;
    assign raw        = {Btn_Clear, Btn_StartStop, Btn_Mode};
    assign unused_lap = Btn_Lap;
`endif

    logic [7:0]    db_cnt [NB];
    logic [NB-1:0] level;
    logic [NB-1:0] level_d;
    logic [NB-1:0] pulse;

    logic [1:0] state;
    logic [1:0] state_next;
    logic [3:0] clr_cnt;
    logic       control;
    logic       start_next;
    logic       stop_next;
    logic       reset_next;
    logic       lap_active;

    logic p_mode;
    logic p_ss;
    logic p_clr;

    assign p_mode = pulse[0];
    assign p_ss   = pulse[1];
    assign p_clr  = pulse[2];

    // Counter restarts whenever raw agrees with the accepted level, so only an
    // unbroken run of DEBOUNCE_MS differing samples flips the level.
    always_ff @(posedge Clock_1MSec) begin
        if (Reset) begin
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
            level   <= '0;
            level_d <= '0;
            pulse   <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (raw[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= raw[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
            level_d <= level;
            pulse   <= level & ~level_d;
        end
    end

    always_ff @(posedge Clock_1MSec) begin
        if (Reset) begin
            state   <= S_IDLE;
            control <= 1'b1;
            clr_cnt <= '0;
            Start_S <= 1'b0;
            Stop_S  <= 1'b0;
            Reset_S <= 1'b0;
        end else begin
            state   <= state_next;
            control <= control ^ p_mode;
            Start_S <= start_next;
            Stop_S  <= stop_next;
            Reset_S <= reset_next;
            if (state != S_CLEAR || state_next != S_CLEAR) begin
                clr_cnt <= '0;
            end else if (!control) begin
                clr_cnt <= clr_cnt + 4'd1;
            end
        end
    end

    // Pulses are judged against the pre-toggle control value; clock mode freezes the FSM.
    always_comb begin
        state_next = state;
        if (!control) begin
            case (state)
                S_IDLE: begin
                    if (p_clr) begin
                        state_next = S_CLEAR;
                    end else if (p_ss) begin
                        state_next = S_RUN;
                    end
                end
                S_RUN: begin
                    if (p_ss) begin
                        state_next = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (p_clr) begin
                        state_next = S_CLEAR;
                    end else if (p_ss) begin
                        state_next = S_RUN;
                    end
                end
                default: begin
                    if (clr_cnt == CLR_LAST) begin
                        state_next = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        start_next = 1'b0;
        stop_next  = 1'b0;
        reset_next = 1'b0;
        case (state_next)
            S_RUN:   start_next = 1'b1;
            S_PAUSE: stop_next  = 1'b1;
            S_CLEAR: reset_next = 1'b1;
            default: ;
        endcase
    end

`ifdef STOPWATCH_LAP_EN
    logic       p_lap;
    logic [3:0] lap_hours;
    logic [5:0] lap_mins;
    logic [5:0] lap_secs;
    logic [9:0] lap_msecs;

    assign p_lap = pulse[3];

    always_ff @(posedge Clock_1MSec) begin
        if (Reset) begin
            lap_hours  <= '0;
            lap_mins   <= '0;
            lap_secs   <= '0;
            lap_msecs  <= '0;
            lap_active <= 1'b0;
        end else if (!control) begin
            if (state_next == S_CLEAR && state != S_CLEAR) begin
                lap_hours  <= '0;
                lap_mins   <= '0;
                lap_secs   <= '0;
                lap_msecs  <= '0;
                lap_active <= 1'b0;
            end else if (p_lap && state == S_RUN) begin
                lap_hours  <= Hours_S;
                lap_mins   <= Mins_S;
                lap_secs   <= Secs_S;
                lap_msecs  <= MSecs_S;
                lap_active <= 1'b1;
            end else if (p_lap && state == S_PAUSE) begin
                lap_active <= 1'b0;
            end
        end
    end

    always_comb begin
        if (lap_active) begin
            Disp_Hours = lap_hours;
            Disp_Mins  = lap_mins;
            Disp_Secs  = lap_secs;
            Disp_MSecs = lap_msecs;
        end else begin
            Disp_Hours = Hours_S;
            Disp_Mins  = Mins_S;
            Disp_Secs  = Secs_S;
            Disp_MSecs = MSecs_S;
        end
    end
`else
    assign lap_active = 1'b0;
    assign Disp_Hours = Hours_S;
    assign Disp_Mins  = Mins_S;
    assign Disp_Secs  = Secs_S;
    assign Disp_MSecs = MSecs_S;
`endif

    assign Control    = control;
    assign Lap_Active = lap_active;
    assign State      = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;               // {lap, clear, startstop, mode}
    logic [3:0] hours;
    logic [5:0] mins;
    logic [5:0] secs;
    logic [9:0] msecs;
    logic       control, start_s, stop_s, reset_s, lap_active;
    logic [3:0] d_hours;
    logic [5:0] d_mins;
    logic [5:0] d_secs;
    logic [9:0] d_msecs;
    logic [1:0] state;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [3:0] B_MODE = 4'b0001;
    localparam logic [3:0] B_SS   = 4'b0010;
    localparam logic [3:0] B_CLR  = 4'b0100;
    localparam logic [3:0] B_LAP  = 4'b1000;

    stopwatch_ctrl #(.DEBOUNCE_MS(20), .CLEAR_CYCLES(2)) dut (
        .Clock_1MSec  (clk),
        .Reset        (rst),
        .Btn_Mode     (btn[0]),
        .Btn_StartStop(btn[1]),
        .Btn_Clear    (btn[2]),
        .Btn_Lap      (btn[3]),
        .Hours_S      (hours),
        .Mins_S       (mins),
        .Secs_S       (secs),
        .MSecs_S      (msecs),
        .Control      (control),
        .Start_S      (start_s),
        .Stop_S       (stop_s),
        .Reset_S      (reset_s),
        .Disp_Hours   (d_hours),
        .Disp_Mins    (d_mins),
        .Disp_Secs    (d_secs),
        .Disp_MSecs   (d_msecs),
        .Lap_Active   (lap_active),
        .State        (state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic [3:0] mask;
        int         hold;
        logic [1:0] exp_state;
        logic       exp_ctl;
        logic [2:0] exp_sss;       // {Start_S, Stop_S, Reset_S}
    } vec_t;

    vec_t vecs[$];

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [1:0] st, input logic ctl,
                              input logic [2:0] sss);
        check({name, ".state"},   32'(state), 32'(st));
        check({name, ".control"}, 32'(control), 32'(ctl));
        check({name, ".sss"},     32'({start_s, stop_s, reset_s}), 32'(sss));
        check({name, ".onehot"},  32'($countones({start_s, stop_s, reset_s}) <= 1), 32'd1);
    endtask

    task automatic check_disp(input string name, input logic [25:0] exp);
        check(name, 32'({d_hours, d_mins, d_secs, d_msecs}), 32'(exp));
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        btn = m;
        cycles(hold);
        btn = 4'b0000;
        cycles(24);
    endtask

    task automatic add_vec(input string nm, input logic [3:0] m, input int h,
                           input logic [1:0] st, input logic ctl, input logic [2:0] sss);
        vec_t v;
        v.name = nm; v.mask = m; v.hold = h;
        v.exp_state = st; v.exp_ctl = ctl; v.exp_sss = sss;
        vecs.push_back(v);
    endtask

    initial begin
        add_vec("glitch19",      B_SS,          19, 2'b00, 1'b0, 3'b000);
        add_vec("idle_start",    B_SS,          20, 2'b01, 1'b0, 3'b100);
        add_vec("run_clr_ign",   B_CLR,         25, 2'b01, 1'b0, 3'b100);
        add_vec("run_pause",     B_SS,          20, 2'b10, 1'b0, 3'b010);
        add_vec("to_clock",      B_MODE,        20, 2'b10, 1'b1, 3'b010);
        add_vec("clk_ss_disc",   B_SS,          20, 2'b10, 1'b1, 3'b010);
        add_vec("clk_clr_disc",  B_CLR,         20, 2'b10, 1'b1, 3'b010);
        add_vec("to_stopwatch",  B_MODE,        20, 2'b10, 1'b0, 3'b010);
        add_vec("resume",        B_SS,          20, 2'b01, 1'b0, 3'b100);
        add_vec("run_clr_ss",    B_CLR | B_SS,  20, 2'b10, 1'b0, 3'b010);
        add_vec("pause_clr_ss",  B_CLR | B_SS,  20, 2'b00, 1'b0, 3'b000);
        add_vec("mode_ss_old0",  B_MODE | B_SS, 20, 2'b01, 1'b1, 3'b100);
        add_vec("mode_ss_old1",  B_MODE | B_SS, 20, 2'b01, 1'b0, 3'b100);
        add_vec("pause2",        B_SS,          20, 2'b10, 1'b0, 3'b010);
        add_vec("clear_idle",    B_CLR,         20, 2'b00, 1'b0, 3'b000);

        rst = 1'b1; btn = 4'b0000;
        hours = 4'd2; mins = 6'd7; secs = 6'd9; msecs = 10'd100;
        cycles(3);
        rst = 1'b0;
        check_outs("reset", 2'b00, 1'b1, 3'b000);
        check("reset.lap_active", 32'(lap_active), 32'd0);
        check_disp("reset.disp_live", {4'd2, 6'd7, 6'd9, 10'd100});

        // Mode latency: Control flips on edge 22 after the first high sample.
        btn = B_MODE;
        cycles(21);
        check("mode_edge21.control", 32'(control), 32'd1);
        cycles(1);
        check("mode_edge22.control", 32'(control), 32'd0);
        check("mode_edge22.state", 32'(state), 32'd0);
        cycles(3);
        btn = 4'b0000;
        cycles(24);

        foreach (vecs[i]) begin
            press(vecs[i].mask, vecs[i].hold);
            check_outs(vecs[i].name, vecs[i].exp_state, vecs[i].exp_ctl, vecs[i].exp_sss);
            check({vecs[i].name, ".lap_active"}, 32'(lap_active), 32'd0);
        end

        // Reset_S stays up for exactly two cycles in CLEAR.
        press(B_SS, 20);
        press(B_SS, 20);
        btn = B_CLR;
        cycles(21);
        check_outs("clr_e21", 2'b10, 1'b0, 3'b010);
        cycles(1);
        check_outs("clr_e22", 2'b11, 1'b0, 3'b001);
        cycles(1);
        check_outs("clr_e23", 2'b11, 1'b0, 3'b001);
        cycles(1);
        check_outs("clr_e24", 2'b00, 1'b0, 3'b000);
        btn = 4'b0000;
        cycles(24);

        // Lap capture and release.
        hours = 4'd0; mins = 6'd1; secs = 6'd23; msecs = 10'd456;
        press(B_SS, 20);
        btn = B_LAP;
        cycles(22);
        hours = 4'd0; mins = 6'd1; secs = 6'd24; msecs = 10'd789;
`ifdef STOPWATCH_LAP_EN
        check("lap_cap.active", 32'(lap_active), 32'd1);
        check_disp("lap_cap.disp_frozen", {4'd0, 6'd1, 6'd23, 10'd456});
`else
        check("lap_cap.active", 32'(lap_active), 32'd0);
        check_disp("lap_cap.disp_live", {4'd0, 6'd1, 6'd24, 10'd789});
`endif
        check_outs("lap_cap", 2'b01, 1'b0, 3'b100);
        btn = 4'b0000;
        cycles(24);
        press(B_SS, 20);
`ifdef STOPWATCH_LAP_EN
        check("lap_pause.active", 32'(lap_active), 32'd1);
`endif
        press(B_LAP, 20);
        check("lap_rel.active", 32'(lap_active), 32'd0);
        check_disp("lap_rel.disp_live", {4'd0, 6'd1, 6'd24, 10'd789});
        check_outs("lap_rel", 2'b10, 1'b0, 3'b010);

        // Reset in the middle of CLEAR.
        btn = B_CLR;
        cycles(22);
        check_outs("pre_rst_clear", 2'b11, 1'b0, 3'b001);
        btn = 4'b0000;
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check_outs("rst_in_clear", 2'b00, 1'b1, 3'b000);
        check("rst_in_clear.lap_active", 32'(lap_active), 32'd0);

        // Reset halfway through a debounce: a full count is needed afterwards.
        btn = B_MODE;
        cycles(10);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(21);
        check("rst_db_e21.control", 32'(control), 32'd1);
        cycles(1);
        check("rst_db_e22.control", 32'(control), 32'd0);
        btn = 4'b0000;
        cycles(24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control sequencer for the stopwatch counter datapath.
- Debounces the front-panel buttons and runs the IDLE/RUN/PAUSE/CLEAR state machine.
- Drives the datapath's Start_S/Stop_S/Reset_S/Control inputs and selects the time shown on the display.
- Sits between the button pads and the stopwatch datapath, clocked by the 1 ms tick.

Parameters:
DEBOUNCE_MS, 20, consecutive stable samples required to accept a button level change (1..255)
CLEAR_CYCLES, 2, cycles Reset_S is held asserted in CLEAR (1..15)

Ports:
Clock_1MSec  input  1  1 kHz system clock
Reset  input  1  synchronous, active-high reset
Btn_Mode  input  1  raw button; toggles clock/stopwatch mode
Btn_StartStop  input  1  raw button; start/pause/resume
Btn_Clear  input  1  raw button; clear stopwatch
Btn_Lap  input  1  raw button; lap/split (used only with STOPWATCH_LAP_EN)
Hours_S  input  4  live hours from datapath
Mins_S  input  6  live minutes
Secs_S  input  6  live seconds
MSecs_S  input  10  live milliseconds
Control  output  1  1 = clock mode, 0 = stopwatch mode
Start_S  output  1  run request to datapath
Stop_S  output  1  hold request to datapath
Reset_S  output  1  clear request to datapath
Disp_Hours  output  4  displayed hours
Disp_Mins  output  6  displayed minutes
Disp_Secs  output  6  displayed seconds
Disp_MSecs  output  10  displayed milliseconds
Lap_Active  output  1  display frozen on captured lap
State  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 CLEAR

Behaviour:
- Reset is synchronous, active-high, one clock, sampled on the Clock_1MSec rising edge. Reset values:
  - State=IDLE; Control=1; Start_S=Stop_S=Reset_S=0; Lap_Active=0.
  - Lap registers=0; all debounce counters=0; debounced levels=0.
- Debounce, per button:
  - An 8-bit counter increments while the raw input differs from the debounced level and clears when it matches.
  - When the counter reaches DEBOUNCE_MS, the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_MS cycles are rejected.
- Edge detect: a rising edge of a debounced level produces a 1-cycle registered pulse. Falling edges are ignored.
- Latency: an output change occurs exactly DEBOUNCE_MS+2 edges after the raw button is first sampled high. All control outputs are registered.
- Mode: a Mode pulse toggles Control in any state.
  - While Control=1, StartStop, Clear and Lap pulses are discarded.
  - While Control=1, the FSM state and all outputs hold.
- FSM transitions:
  - IDLE: StartStop -> RUN; Clear -> CLEAR.
  - RUN: StartStop -> PAUSE; Clear ignored.
  - PAUSE: StartStop -> RUN; Clear -> CLEAR.
  - CLEAR: after CLEAR_CYCLES cycles -> IDLE unconditionally; button pulses ignored.
- FSM outputs, registered to match the state:
  - IDLE: 0/0/0 (Start_S/Stop_S/Reset_S).
  - RUN: Start_S=1.
  - PAUSE: Stop_S=1.
  - CLEAR: Reset_S=1, Start_S=Stop_S=0.
  - At most one of Start_S/Stop_S/Reset_S is ever high.
- Simultaneous pulses, same cycle:
  - IDLE or PAUSE: Clear has priority over StartStop.
  - RUN: StartStop wins.
  - Mode toggles Control, and the other pulses of that cycle are evaluated under the old Control value.
- Display: combinational mux. Disp_* = lap registers when Lap_Active=1, else the live Hours_S..MSecs_S inputs.
- Reset mid-operation, including mid-CLEAR or mid-debounce: all state returns to reset values on the next edge.

Optional Feature:
STOPWATCH_LAP_EN
- Defined:
  - Lap pulse in RUN loads the lap registers with Hours_S..MSecs_S sampled that cycle and sets Lap_Active=1. A repeated Lap in RUN recaptures.
  - Lap pulse in PAUSE clears Lap_Active.
  - Lap in IDLE or CLEAR is ignored.
  - Entering CLEAR zeroes the lap registers and clears Lap_Active.
  - Lap and StartStop in the same cycle in RUN: the capture happens and the state moves to PAUSE.
- Undefined: Btn_Lap is ignored, no lap registers exist, Lap_Active is tied 0, and Disp_* pass the live inputs through.

Test Plan:
1. Reset, then Btn_Mode high 25 cycles (DEBOUNCE_MS=20) -> Control goes 1->0 exactly 22 edges after the first high sample; State=00.
2. Control=0, Btn_StartStop high 19 cycles then low -> no change. High 20 cycles -> State=01, Start_S=1 at edge 22.
3. RUN -> StartStop -> PAUSE (Stop_S=1) -> Clear -> Reset_S=1 for exactly 2 cycles -> IDLE with all outputs 0.
4. RUN, Clear and StartStop pulses in the same cycle -> PAUSE. Then, in PAUSE, Clear and StartStop pulses in the same cycle -> CLEAR.
5. LAP_EN, RUN with live 0:01:23.456 at the Lap pulse -> Disp shows 0/1/23/456 with Lap_Active=1 while live advances. StartStop then Lap -> Lap_Active=0 and Disp=live.
6. Reset asserted during CLEAR and during a half-complete debounce -> State=IDLE, Control=1, outputs 0, and the button needs a full DEBOUNCE_MS again.
